freelist_ctrl: RTL
==================

// Module: freelist_ctrl
// PURPOSE
//  Sequencer for the rename unit's physical-register free list, which is held in a 2-in/2-out FIFO (f2if2o).
//  After reset it fills the FIFO with the initially free physical registers, two per cycle.
//  It then grants rename allocations of up to 2 pregs/cycle and returns committed pregs of up to 2/cycle.
//  It compacts single-lane requests onto FIFO lane 0 and flags overflow (release into a full list).
// PARAMETERS
//  PREG_NUM      64  total physical registers
//  PREG_WIDTH    6   preg index width (= FIFO data width)
//  FL_SIZE       32  free-list depth (= FIFO_SIZE); must be even and <= PREG_NUM
//  FL_SIZE_WIDTH 5   log2(FL_SIZE)
// PORTS
//  clk              in   1               clock
//  rst              in   1               synchronous reset, active-high
//  alloc_req_i      in   2               rename lane requests, bit0 = lane0, bit1 = lane1
//  alloc_gnt_o      out  1               all requested lanes granted this cycle
//  alloc_preg0_o    out  PREG_WIDTH      preg for lane0; valid when gnt & req[0]
//  alloc_preg1_o    out  PREG_WIDTH      preg for lane1; valid when gnt & req[1]
//  rel_vld_i        in   2               commit release valids, per lane
//  rel_preg0_i      in   PREG_WIDTH      released preg, lane0
//  rel_preg1_i      in   PREG_WIDTH      released preg, lane1
//  fl_ready_o       out  1               init done; state == RUN
//  free_cnt_o       out  FL_SIZE_WIDTH+1 free pregs (= fifo_num_i)
//  overflow_err_o   out  1               sticky release-overflow / illegal-release error
//  fifo_wr_first_o  out  1               to FIFO wr_first_en_i
//  fifo_wr_second_o out  1               to FIFO wr_second_en_i
//  fifo_wdata0_o    out  PREG_WIDTH      to FIFO wdata_first_i
//  fifo_wdata1_o    out  PREG_WIDTH      to FIFO wdata_second_i
//  fifo_rd_first_o  out  1               to FIFO rd_first_en_i
//  fifo_rd_second_o out  1               to FIFO rd_second_en_i
//  fifo_rdata0_i    in   PREG_WIDTH      from FIFO rdata_first_o (combinational read)
//  fifo_rdata1_i    in   PREG_WIDTH      from FIFO rdata_second_o
//  fifo_num_i       in   FL_SIZE_WIDTH+1 from FIFO fifo_num_o
// BEHAVIOUR
//  The FIFO shares clk/rst. All outputs are combinational from state, counters and inputs.
//  The only registers are state, init_cnt and err.
//  Reset: state=INIT, init_cnt=0, err=0. Outputs during/after reset: gnt=0, all fifo enables=0,
//   fl_ready=0, overflow_err=0.
//  FSM INIT:
//   - wr_first=wr_second=1, wdata0 = PREG_NUM-FL_SIZE+2*init_cnt, wdata1 = wdata0+1.
//   - init_cnt increments each cycle. When init_cnt == FL_SIZE/2-1 -> RUN.
//   - Fill takes FL_SIZE/2 cycles; default writes pregs 32..63 in 16 cycles.
//   - alloc_gnt=0 in INIT.
//   - Any rel_vld in INIT is ignored and sets err.
//  FSM RUN:
//   - Stays in RUN until rst. Reset mid-INIT or mid-RUN restarts INIT from init_cnt=0.
//  Alloc (RUN), n = popcount(alloc_req_i):
//   - gnt = (n != 0) & (fifo_num_i >= n). Grants are all-or-nothing; a 2-lane request with 1 free grants neither.
//   - req=01: rd_first=1, preg0 = rdata0.
//   - req=10: rd_first=1, preg1 = rdata0 (compacted onto lane 0).
//   - req=11: rd_first=rd_second=1, preg0 = rdata0, preg1 = rdata1.
//   - No grant: rd enables=0. Ungranted preg outputs are 0.
//  Release (RUN), m = popcount(rel_vld_i):
//   - Never back-pressured.
//   - rel=01: wr_first, wdata0 = rel_preg0.
//   - rel=10: wr_first, wdata0 = rel_preg1.
//   - rel=11: both lanes, wdata0 = rel_preg0, wdata1 = rel_preg1.
//  Overflow:
//   - Condition: fifo_num_i - n_granted + m > FL_SIZE (evaluate in FL_SIZE_WIDTH+2 bits).
//   - On overflow, all writes that cycle are suppressed and err is set.
//   - Allocs that cycle still proceed.
//  No bypass: a preg released in cycle t is allocatable from t+1. At fifo_num=0 with same-cycle release, gnt=0.
//  Simultaneous alloc and release: both proceed. Next-cycle free_cnt = fifo_num - n_granted + m.
//  Pointer wrap-around is handled inside the FIFO. free_cnt_o mirrors fifo_num_i.
// TESTING
//  1. rst 1 cycle, then idle -> fl_ready rises after 16 cycles; free_cnt=32.
//     Allocations drain pregs 32,33,...,63 in order.
//  2. RUN, req=11 x16 cycles -> gnt each cycle, pregs (32,33)..(62,63); free_cnt=0.
//     Next req=01 -> gnt=0.
//  3. free_cnt=1, req=11 -> gnt=0, no rd enables.
//     Same state, req=10 -> gnt=1, preg1 = head, rd_first only.
//  4. free_cnt=0, rel=10 with preg 5, req=01 same cycle -> gnt=0.
//     Next cycle: free_cnt=1, req=01 -> gnt=1, preg0=5.
//  5. free_cnt=32, rel=01 -> overflow_err=1 (sticky), free_cnt stays 32.
//     rst -> err clears.
//  6. rst asserted at INIT cycle 7 -> restart; exactly 16 fill cycles afterwards and the list holds 32..63.

Source files
------------

// File: rtl/freelist_ctrl.sv
// Free-list sequencer for the rename unit: fills the 2-in/2-out free-list FIFO after reset,
// then grants up to two allocations and accepts up to two releases per cycle.
module freelist_ctrl #(
    parameter int PREG_NUM      = 64,
    parameter int PREG_WIDTH    = 6,
    parameter int FL_SIZE       = 32,
    parameter int FL_SIZE_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               alloc_req_i,
    output logic                     alloc_gnt_o,
    output logic [PREG_WIDTH-1:0]    alloc_preg0_o,
    output logic [PREG_WIDTH-1:0]    alloc_preg1_o,
    input  logic [1:0]               rel_vld_i,
    input  logic [PREG_WIDTH-1:0]    rel_preg0_i,
    input  logic [PREG_WIDTH-1:0]    rel_preg1_i,
    output logic                     fl_ready_o,
    output logic [FL_SIZE_WIDTH:0]   free_cnt_o,
    output logic                     overflow_err_o,
    output logic                     fifo_wr_first_o,
    output logic                     fifo_wr_second_o,
    output logic [PREG_WIDTH-1:0]    fifo_wdata0_o,
    output logic [PREG_WIDTH-1:0]    fifo_wdata1_o,
    output logic                     fifo_rd_first_o,
    output logic                     fifo_rd_second_o,
    input  logic [PREG_WIDTH-1:0]    fifo_rdata0_i,
    input  logic [PREG_WIDTH-1:0]    fifo_rdata1_i,
    input  logic [FL_SIZE_WIDTH:0]   fifo_num_i
);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam int CW = FL_SIZE_WIDTH + 2;
    localparam logic [PREG_WIDTH-1:0]    INIT_BASE = PREG_WIDTH'(PREG_NUM - FL_SIZE);
    localparam logic [FL_SIZE_WIDTH-1:0] INIT_LAST = FL_SIZE_WIDTH'(FL_SIZE / 2 - 1);

    state_e                   state_q, state_d;
    logic [FL_SIZE_WIDTH-1:0] initCnt_q, initCnt_d;
    logic                     err_q, err_d;

    logic          runActive;
    logic          gnt;
    logic          overflow;
    logic [1:0]    reqCnt;
    logic [1:0]    relCnt;
    logic [1:0]    grantCnt;
    logic [CW-1:0] projectedNum;

    assign reqCnt    = {1'b0, alloc_req_i[0]} + {1'b0, alloc_req_i[1]};
    assign relCnt    = {1'b0, rel_vld_i[0]} + {1'b0, rel_vld_i[1]};
    assign runActive = (state_q == RUN) && !rst;

    // Grants are all-or-nothing and only use entries already in the FIFO (no release bypass).
    assign gnt          = runActive && (reqCnt != 2'd0) && (fifo_num_i >= (FL_SIZE_WIDTH+1)'(reqCnt));
    assign grantCnt     = gnt ? reqCnt : 2'd0;
    assign projectedNum = CW'(fifo_num_i) - CW'(grantCnt) + CW'(relCnt);
    assign overflow     = runActive && (projectedNum > CW'(FL_SIZE));

    assign alloc_gnt_o    = gnt;
    assign fl_ready_o     = runActive;
    assign free_cnt_o     = fifo_num_i;
    assign overflow_err_o = err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            initCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        initCnt_d        = initCnt_q;
        err_d            = err_q;
        alloc_preg0_o    = '0;
        alloc_preg1_o    = '0;
        fifo_wr_first_o  = 1'b0;
        fifo_wr_second_o = 1'b0;
        fifo_wdata0_o    = '0;
        fifo_wdata1_o    = '0;
        fifo_rd_first_o  = 1'b0;
        fifo_rd_second_o = 1'b0;

        case (state_q)
            INIT: begin
                fifo_wr_first_o  = !rst;
                fifo_wr_second_o = !rst;
                fifo_wdata0_o    = INIT_BASE + PREG_WIDTH'({initCnt_q, 1'b0});
                fifo_wdata1_o    = INIT_BASE + PREG_WIDTH'({initCnt_q, 1'b1});
                initCnt_d        = initCnt_q + 1'b1;
                if (initCnt_q == INIT_LAST) begin
                    state_d = RUN;
                end
                if (rel_vld_i != 2'b00) begin
                    err_d = 1'b1;
                end
            end

            RUN: begin
                // A lone lane-1 request is served from FIFO lane 0.
                if (gnt) begin
                    fifo_rd_first_o  = 1'b1;
                    fifo_rd_second_o = (alloc_req_i == 2'b11);
                    case (alloc_req_i)
                        2'b01: alloc_preg0_o = fifo_rdata0_i;
                        2'b10: alloc_preg1_o = fifo_rdata0_i;
                        2'b11: begin
                            alloc_preg0_o = fifo_rdata0_i;
                            alloc_preg1_o = fifo_rdata1_i;
                        end
                        default: ;
                    endcase
                end

                if (overflow) begin
                    err_d = 1'b1;
                end else if (!rst) begin
                    case (rel_vld_i)
                        2'b01: begin
                            fifo_wr_first_o = 1'b1;
                            fifo_wdata0_o   = rel_preg0_i;
                        end
                        2'b10: begin
                            fifo_wr_first_o = 1'b1;
                            fifo_wdata0_o   = rel_preg1_i;
                        end
                        2'b11: begin
                            fifo_wr_first_o  = 1'b1;
                            fifo_wr_second_o = 1'b1;
                            fifo_wdata0_o    = rel_preg0_i;
                            fifo_wdata1_o    = rel_preg1_i;
                        end
                        default: ;
                    endcase
                end
            end

            default: ;
        endcase
    end

endmodule
